// File: rtl/pdm_sd.sv
// Multi-channel PDM sigma-delta modulator with selectable first/second order,
// a step divider and a single-entry sample buffer in front of the active word.
module pdm_sd #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int DIV      = 1,
  parameter int SIGNED   = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        order2_i,
  input  logic                        sample_valid_i,
  input  logic [CHANNELS*DEPTH-1:0]   sample_i,
  output logic                        sample_ready_o,
  output logic [CHANNELS-1:0]         pdm_o,
  output logic                        tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam int IW = DEPTH + 3;
  localparam int W  = DEPTH + 5;
  localparam logic signed [W-1:0] HALF = W'(2 ** (DEPTH - 1));
  localparam logic signed [W-1:0] SMAX = W'(2 ** (DEPTH + 2) - 1);
  localparam logic signed [W-1:0] SMIN = ~SMAX;
  localparam logic [DEPTH-1:0] FLIP =
    (SIGNED != 0) ? {1'b1, {(DEPTH-1){1'b0}}} : {DEPTH{1'b0}};

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          pend_full_q, pend_full_d;
  logic [CHANNELS*DEPTH-1:0]     pend_q, pend_d, act_q, act_d;
  logic                          mode_q, mode_d;
  logic [CHANNELS-1:0]           pdm_q, pdm_d;
  logic [CHANNELS-1:0][DEPTH-1:0] acc_q, acc_d, fo_acc;
  logic [CHANNELS-1:0][IW-1:0]   i1_q, i1_d, i2_q, i2_d, so_i1, so_i2;
  logic [CHANNELS-1:0]           fo_y, so_y;
  logic                          tick, accept;

  function automatic logic [IW-1:0] sat(input logic signed [W-1:0] v);
    if (v > SMAX) return SMAX[IW-1:0];
    else if (v < SMIN) return SMIN[IW-1:0];
    else return v[IW-1:0];
  endfunction

  function automatic logic signed [W-1:0] sext(input logic [IW-1:0] v);
    return $signed({{(W-IW){v[IW-1]}}, v});
  endfunction

  // Reset also masks tick combinationally so DIV=1 cannot pulse while in reset.
  assign tick           = en_i & ~rst_i & (cnt_q == LAST);
  assign tick_o         = tick;
  assign sample_ready_o = ~pend_full_q | tick;
  assign accept         = sample_valid_i & sample_ready_o;
  assign pdm_o          = en_i ? pdm_q : '0;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DEPTH-1:0]      u;
    logic [DEPTH:0]        s;
    logic signed [W-1:0]   fb, s1, s2;
    assign u         = act_q[c*DEPTH +: DEPTH] ^ FLIP;
    assign s         = {1'b0, acc_q[c]} + {1'b0, u};
    assign fo_acc[c] = s[DEPTH-1:0];
    assign fo_y[c]   = s[DEPTH];
    // previous y is the registered pdm bit
    assign fb        = pdm_q[c] ? HALF : -HALF;
    assign s1        = sext(i1_q[c]) + $signed({{(W-DEPTH){1'b0}}, u}) - HALF - fb;
    assign so_i1[c]  = sat(s1);
    assign s2        = sext(i2_q[c]) + sext(so_i1[c]) - fb;
    assign so_i2[c]  = sat(s2);
    assign so_y[c]   = ~so_i2[c][IW-1];
  end

  always_comb begin
    cnt_d       = (!en_i || tick) ? '0 : cnt_q + 1'b1;
    pend_d      = accept ? sample_i : pend_q;
    pend_full_d = accept | (pend_full_q & ~tick);
    act_d       = (tick & pend_full_q) ? pend_q : act_q;
  end

  always_comb begin
    mode_d = mode_q;
    pdm_d  = pdm_q;
    acc_d  = acc_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    if (!en_i || (tick && (order2_i != mode_q))) begin
      acc_d  = '0;
      i1_d   = '0;
      i2_d   = '0;
      pdm_d  = '0;
      mode_d = en_i & order2_i;
    end else if (tick) begin
      if (mode_q) begin
        i1_d  = so_i1;
        i2_d  = so_i2;
        pdm_d = so_y;
      end else begin
        acc_d = fo_acc;
        pdm_d = fo_y;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
      mode_q      <= 1'b0;
      pdm_q       <= '0;
      acc_q       <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      mode_q      <= mode_d;
      pdm_q       <= pdm_d;
      acc_q       <= acc_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
    end
  end
endmodule

// File: tb/tb_pdm_sd.sv
// Bench for pdm_sd: instance A (2ch, DIV=1, unsigned) tracked by a reference
// model every cycle; instance B (1ch, DIV=4, signed) for handshake and density.
module tb_pdm_sd;
  localparam int D     = 8;
  localparam int A_DIV = 1;
  localparam int B_DIV = 4;
  localparam int FULL  = 1 << D;
  localparam int HALF  = FULL / 2;
  localparam int LIM   = 4 * FULL;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_o2, a_valid, a_ready, a_tick;
  logic [15:0] a_sample;
  logic [1:0]  a_pdm;
  logic        b_en, b_o2, b_valid, b_ready, b_tick;
  logic [7:0]  b_sample;
  logic [0:0]  b_pdm;

  pdm_sd #(.CHANNELS(2), .DEPTH(D), .DIV(A_DIV), .SIGNED(0)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(a_en), .order2_i(a_o2),
    .sample_valid_i(a_valid), .sample_i(a_sample),
    .sample_ready_o(a_ready), .pdm_o(a_pdm), .tick_o(a_tick));

  pdm_sd #(.CHANNELS(1), .DEPTH(D), .DIV(B_DIV), .SIGNED(1)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(b_en), .order2_i(b_o2),
    .sample_valid_i(b_valid), .sample_i(b_sample),
    .sample_ready_o(b_ready), .pdm_o(b_pdm), .tick_o(b_tick));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit inst_b; bit o2; int s0; int s1; int nticks; int exp0; int exp1; int tol;
  } row_t;
  row_t rows[9];

  // reference model state for instance A
  int          m_run;
  logic [15:0] m_pend[$];
  logic [15:0] m_act;
  bit          m_mode;
  int          m_acc[2], m_i1[2], m_i2[2];
  bit          m_y[2];
  bit          e_tick, e_ready;
  logic [1:0]  e_pdm;

  logic       s_a_tick, s_a_ready, s_b_tick, s_b_ready, s_b_pdm;
  logic [1:0] s_a_pdm;
  bit         mon_sat = 0;
  int         sat_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > LIM - 1) ? LIM - 1 : ((v < -LIM) ? -LIM : v);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
    end
  endtask

  task automatic model_reset();
    m_run = 0;
    m_pend.delete();
    m_act = '0;
    m_mode = 0;
    model_clear();
  endtask

  task automatic model_check();
    e_tick  = a_en && ((m_run % A_DIV) == A_DIV - 1);
    e_ready = (m_pend.size() == 0) || e_tick;
    for (int c = 0; c < 2; c++) e_pdm[c] = a_en && m_y[c];
    chk("a_tick", a_tick, e_tick);
    chk("a_ready", a_ready, e_ready);
    chk("a_pdm", a_pdm, e_pdm);
  endtask

  task automatic model_edge();
    bit take;
    int u, x, fb;
    take = a_valid && e_ready;
    if (!a_en) begin
      model_clear();
      m_mode = 0;
    end else if (e_tick) begin
      if (a_o2 != m_mode) begin
        model_clear();
        m_mode = a_o2;
      end else begin
        for (int c = 0; c < 2; c++) begin
          u = int'(m_act[c*D +: D]);
          if (!m_mode) begin
            m_acc[c] += u;
            m_y[c] = (m_acc[c] >= FULL);
            if (m_y[c]) m_acc[c] -= FULL;
          end else begin
            x  = u - HALF;
            fb = m_y[c] ? HALF : -HALF;
            m_i1[c] = clamp(m_i1[c] + x - fb);
            m_i2[c] = clamp(m_i2[c] + m_i1[c] - fb);
            m_y[c]  = (m_i2[c] >= 0);
          end
        end
      end
    end
    if (e_tick && m_pend.size() != 0) m_act = m_pend.pop_front();
    if (take) m_pend.push_back(a_sample);
    m_run = a_en ? m_run + 1 : 0;
  endtask

  task automatic step();
    int v1, v2;
    @(negedge clk);
    s_a_tick = a_tick; s_a_ready = a_ready; s_a_pdm = a_pdm;
    s_b_tick = b_tick; s_b_ready = b_ready; s_b_pdm = b_pdm[0];
    model_check();
    if (mon_sat) begin
      for (int c = 0; c < 2; c++) begin
        v1 = int'($signed(u_a.i1_q[c]));
        v2 = int'($signed(u_a.i2_q[c]));
        if (v1 >= LIM - 1 || v1 <= -LIM || v2 >= LIM - 1 || v2 <= -LIM) sat_hits++;
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic release_reset();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_en = 0; a_valid = 0; b_en = 0; b_valid = 0;
    #1;
    release_reset();
  endtask

  task automatic run_row(input row_t r);
    int n, cyc, ones0, ones1, hold_err;
    logic prev_p;
    logic prev_t;
    do_reset();
    n = 0; cyc = 0; ones0 = 0; ones1 = 0; hold_err = 0; sat_hits = 0;
    if (!r.inst_b) begin
      a_valid = 1; a_sample = {8'(r.s1), 8'(r.s0)};
      step();
      a_valid = 0; a_en = 1; a_o2 = r.o2; mon_sat = r.o2;
      repeat (3) step();
      while (n < r.nticks && cyc < r.nticks * A_DIV + 50) begin
        step(); cyc++;
        if (s_a_tick) begin
          n++; ones0 += int'(s_a_pdm[0]); ones1 += int'(s_a_pdm[1]);
        end
      end
      mon_sat = 0;
      chk("a_tick_budget", n, r.nticks);
      chk_rng("a_ones_ch0", ones0, r.exp0 - r.tol, r.exp0 + r.tol);
      chk_rng("a_ones_ch1", ones1, r.exp1 - r.tol, r.exp1 + r.tol);
      if (r.o2) chk("a_no_sat", sat_hits, 0);
    end else begin
      b_valid = 1; b_sample = 8'(r.s0);
      step();
      b_valid = 0; b_en = 1; b_o2 = r.o2;
      while (n < 3 && cyc < 100) begin
        step(); cyc++;
        if (s_b_tick) n++;
      end
      n = 0; cyc = 0;
      prev_p = s_b_pdm; prev_t = s_b_tick;
      while (n < r.nticks && cyc < r.nticks * B_DIV + 50) begin
        step(); cyc++;
        if (!prev_t && s_b_pdm !== prev_p) hold_err++;
        prev_p = s_b_pdm; prev_t = s_b_tick;
        if (s_b_tick) begin
          n++; ones0 += int'(s_b_pdm);
        end
      end
      chk("b_tick_budget", n, r.nticks);
      chk_rng("b_ones", ones0, r.exp0 - r.tol, r.exp0 + r.tol);
      chk("b_pdm_hold", hold_err, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w1, w2;
    bit exp_r[5];
    bit exp_t[5];
    int cyc;
    //          inst o2  s0    s1   n     e0   e1  tol
    rows[0] = '{0,  0,  64,   192, 256,  64,  192, 0};
    rows[1] = '{0,  0,  0,    255, 256,  0,   255, 0};
    rows[2] = '{0,  0,  255,  0,   256,  255, 0,   0};
    rows[3] = '{0,  0,  100,  37,  256,  100, 37,  0};
    rows[4] = '{0,  1,  128,  128, 1024, 512, 512, 2};
    rows[5] = '{1,  0,  8'h00, 0,  256,  128, 0,   0};
    rows[6] = '{1,  0,  8'h7F, 0,  256,  255, 0,   0};
    rows[7] = '{1,  0,  8'h80, 0,  256,  0,   0,   0};
    rows[8] = '{1,  0,  8'hC0, 0,  256,  64,  0,   0};

    // reset state with en high: tick must stay low, ready high
    rst = 1; a_en = 1; a_o2 = 0; a_valid = 0; a_sample = '0;
    b_en = 1; b_o2 = 0; b_valid = 0; b_sample = '0;
    #2;
    chk("rst_a_tick", a_tick, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_pdm", a_pdm, 0);
    chk("rst_b_tick", b_tick, 0);
    chk("rst_b_ready", b_ready, 1);
    a_en = 0; b_en = 0;
    release_reset();

    for (int i = 0; i < 9; i++) run_row(rows[i]);

    // ch0 = 64 gives exactly one 1 every 4 ticks once settled
    do_reset();
    a_valid = 1; a_sample = {8'd192, 8'd64};
    step();
    a_valid = 0; a_en = 1; a_o2 = 0;
    repeat (4) step();
    begin
      int per_win_bad;
      int ones;
      per_win_bad = 0;
      for (int k = 0; k < 16; k++) begin
        ones = 0;
        for (int j = 0; j < 4; j++) begin
          step();
          ones += int'(s_a_pdm[0]);
        end
        if (ones != 1) per_win_bad++;
      end
      chk("ch0_one_in_four", per_win_bad, 0);
    end

    // order switch mid-run clears integrators and forces pdm low
    do_reset();
    a_valid = 1; a_sample = {8'd192, 8'd64};
    step();
    a_valid = 0; a_en = 1; a_o2 = 1;
    repeat (40) step();
    a_o2 = 0;
    step();
    chk("sw12_pdm", a_pdm, 0);
    chk("sw12_i1", u_a.i1_q, 0);
    chk("sw12_i2", u_a.i2_q, 0);
    chk("sw12_acc", u_a.acc_q, 0);
    repeat (20) step();
    a_o2 = 1;
    step();
    chk("sw21_pdm", a_pdm, 0);
    chk("sw21_acc", u_a.acc_q, 0);
    chk("sw21_i1", u_a.i1_q, 0);
    repeat (20) step();

    // DIV=4 handshake from reset, then asynchronous reset mid-cycle
    w1 = 8'h35; w2 = 8'h9A;
    exp_r = '{1, 0, 0, 1, 0};
    exp_t = '{0, 0, 0, 1, 0};
    do_reset();
    a_valid = 1; a_sample = 16'hFFFF;
    b_en = 1; b_valid = 1; b_sample = w1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a_valid = 0; a_en = 1; b_sample = w2;
      end
      step();
      chk($sformatf("hs_ready_%0d", i), s_b_ready, exp_r[i]);
      chk($sformatf("hs_tick_%0d", i), s_b_tick, exp_t[i]);
    end
    chk("hs_active_w1", u_b.act_q, w1);
    b_valid = 0;
    #2;
    chk("pre_rst_b_ready", b_ready, 0);
    rst = 1;
    #1;
    chk("arst_a_pdm", a_pdm, 0);
    chk("arst_a_tick", a_tick, 0);
    chk("arst_a_ready", a_ready, 1);
    chk("arst_b_ready", b_ready, 1);
    chk("arst_b_tick", b_tick, 0);
    chk("arst_b_pdm", b_pdm, 0);
    chk("arst_b_active", u_b.act_q, 0);
    release_reset();
    a_en = 0;
    b_en = 1; b_valid = 1; b_sample = w2;
    cyc = 0;
    do begin
      step(); cyc++;
      b_valid = 0;
    end while (!s_b_tick && cyc < 20);
    chk("first_tick_cycle", cyc, B_DIV);
    chk("hs_active_w2", u_b.act_q, w2);
    cyc = 0;
    do begin
      step(); cyc++;
    end while (!s_b_tick && cyc < 20);
    chk("repeat_tick_cycle", cyc, B_DIV);
    chk("repeat_active_w2", u_b.act_q, w2);
    chk("repeat_ready", b_ready, 1);

    // randomized traffic on instance A against the model
    do_reset();
    a_o2 = 0;
    for (int i = 0; i < 3000; i++) begin
      a_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 63) == 0) a_o2 = ~a_o2;
      a_valid = ($urandom_range(0, 1) == 1);
      a_sample = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pdm_sd.md
PDM_SD -- requirements
Module: pdm_sd

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent modulator channels, at least 1.
REQ-002 Parameter DEPTH, default 8: sample width in bits, at least 2.
REQ-003 Parameter DIV, default 1: clk cycles per modulation step, at least 1.
REQ-004 Parameter SIGNED, default 0: 1 means input samples are two's complement, 0 means unsigned.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  modulator enable.
REQ-008 order2  in  1  0 selects first-order modulation, 1 selects second-order.
REQ-009 sample_valid  in  1  a sample word is offered.
REQ-010 sample  in  CHANNELS*DEPTH  channel c occupies bits [c*DEPTH +: DEPTH].
REQ-011 sample_ready  out  1  the offered sample word is accepted this cycle.
REQ-012 pdm  out  CHANNELS  registered 1-bit density output, one bit per channel.
REQ-013 tick  out  1  one-cycle pulse marking each modulation step.

Function
REQ-014 Step divider: counter runs 0..DIV-1 while en=1 and wraps to 0; tick=1 exactly in the cycle the counter equals DIV-1; with DIV=1, tick=en.
REQ-015 en=0: counter held at 0, tick=0, all integrators and the mode latch cleared synchronously, pdm bits forced to 0 in the same cycle (combinational gating).
REQ-016 Buffering: single-entry pending register feeding an active register; transfer happens on a tick when pending is full.
REQ-017 sample_ready = (pending empty) OR tick.
REQ-018 A transfer occurs when sample_valid AND sample_ready; the accepted word enters pending.
REQ-019 Accept and tick in the same cycle: old pending moves to active and the new word becomes pending; no word is lost or duplicated.
REQ-020 A tick with pending empty leaves active unchanged, so the last sample is repeated.
REQ-021 The buffer operates regardless of en.
REQ-022 Input normalisation: u = active word; if SIGNED=1, u = word with MSB inverted (offset binary); u lies in 0..2^DEPTH-1.
REQ-023 First-order, per channel on tick: s = acc + u (DEPTH+1 bits); y = s[DEPTH]; acc <= s[DEPTH-1:0]; pdm <= y.
REQ-024 First-order density over 2^DEPTH consecutive ticks of a constant u is exactly u ones.
REQ-025 Second-order, per channel on tick: x = u - 2^(DEPTH-1) (signed); fb = +2^(DEPTH-1) if the previous y=1, else -2^(DEPTH-1).
REQ-026 Second-order integrator updates: i1 <= sat(i1 + x - fb); i2 <= sat(i2 + i1_new - fb); y = (i2_new >= 0); pdm <= y.
REQ-027 Second-order integrators are DEPTH+3 bits signed, saturating at -(2^(DEPTH+2)) and 2^(DEPTH+2)-1; wrap-around is forbidden.
REQ-028 The mode latch captures order2 on each tick.
REQ-029 On a tick where order2 differs from the latched mode: acc, i1 and i2 cleared, previous y cleared, pdm <= 0, and the new mode takes effect from the next tick.
REQ-030 pdm bits change only on a tick (or go to 0 via en/rst); they hold between ticks.
REQ-031 All channels share tick, mode and handshake; channel arithmetic is independent.

Reset
REQ-032 rst=1 asynchronously clears the counter, pending (empty), active (0), acc, i1, i2, previous y and mode latch (first-order), and drives pdm=0 and tick=0.
REQ-033 While rst=1 and immediately after its release, sample_ready=1.
REQ-034 The first tick occurs DIV cycles after rst is deasserted with en=1.

Verification
REQ-035 CHANNELS=2, DEPTH=8, DIV=1, order2=0, constant ch0=64 and ch1=192 -> exactly 64 and 192 ones per 256 ticks; ch0 shows one 1 every 4 ticks.
REQ-036 order2=0 with u=0 -> pdm stays 0; with u=255 -> 255 ones per 256 ticks.
REQ-037 DIV=4, two words offered back-to-back from reset -> first accepted immediately, second accepted only on the tick cycle; active updates on that tick.
REQ-038 order2=1, u=128 -> 512±2 ones over 1024 ticks; i1 and i2 never reach saturation; toggling order2 mid-run -> pdm=0 on the switching tick and integrators are zero.
REQ-039 SIGNED=1 with sample=0x00 -> 128 ones per 256 ticks (first-order).
REQ-040 rst asserted between clock edges mid-run -> pdm=0, tick=0 and sample_ready=1 before the next edge.
